// File: rtl/fpalu_sequencer_pkg.sv
// fpalu_sequencer_pkg
//    Shared constants for the FPALU issue/completion sequencer: the FP opcode
//    encodings seen on icontrol/ofp_control, the pattern written back when an
//    operation times out, and the sequencer state encoding.
package fpalu_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_BUSY = 2'd1,
        SEQ_DONE = 2'd2
    } seqState_e;

    localparam logic [4:0] FOPNULL  = 5'd0;
    localparam logic [4:0] FOPADD   = 5'd1;
    localparam logic [4:0] FOPSUB   = 5'd2;
    localparam logic [4:0] FOPMUL   = 5'd3;
    localparam logic [4:0] FOPDIV   = 5'd4;
    localparam logic [4:0] FOPSQRT  = 5'd5;
    localparam logic [4:0] FOPABS   = 5'd6;
    localparam logic [4:0] FOPCEQ   = 5'd7;
    localparam logic [4:0] FOPCVTWS = 5'd8;
    localparam logic [4:0] FOPMV    = 5'd9;

    localparam logic [31:0] FP_ERROR_PATTERN = 32'hEEEEEEEE;

    // A new request can only be taken when no operation is holding FPALU.
    function automatic logic canAccept(input seqState_e state);
        return (state == SEQ_IDLE) || (state == SEQ_DONE);
    endfunction

endpackage

// File: rtl/fpalu_sequencer_watchdog.sv
// fpalu_seq_watchdog
//    Counts cycles spent in BUSY and flags the cycle in which the limit is
//    reached, so the sequencer can give up on an FPALU that never answers.
//    Only instantiated when FPALU_SEQ_TIMEOUT_EN is defined.
//
//    clock_i   : clock
//    reset_i   : synchronous active-high reset
//    busy_i    : sequencer is in BUSY this cycle
//    clear_i   : flush; drops the count back to zero
//    expired_o : this is the TIMEOUT_CYCLES-th BUSY cycle
module fpalu_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic busy_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count is zero on the first BUSY cycle because it is held clear in
    // every non-BUSY cycle; it saturates so a late ready cannot wrap it.
    always_comb begin
        count_d = '0;
        if (busy_i && !clear_i) begin
            count_d = (count_q == LAST) ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = busy_i && (count_q == LAST);

endmodule

// File: rtl/fpalu_sequencer.sv
// fpalu_sequencer
//    Issue/completion controller between the execute stage and the
//    multi-cycle FPALU. Takes one request at a time, keeps its operands stable
//    on the ofp_* outputs while ofp_start is high, waits for ifp_ready and
//    presents the result as a one-cycle writeback. Stalls the core while busy
//    and aborts the operation on iflush.
//
//    Optional feature: define FPALU_SEQ_TIMEOUT_EN to add a watchdog that
//    completes a stuck operation after TIMEOUT_CYCLES BUSY cycles with the
//    error pattern and an oerror pulse. Without it oerror is tied low.
//
//    iclock, ireset            : clock, synchronous active-high reset
//    ivalid, icontrol          : request present, FP opcode
//    idataa, idatab            : operands
//    ird, iwb_int              : destination index, integer-file target
//    iflush                    : abort current or incoming request
//    oaccept, ostall           : request taken this cycle, core must hold
//    ofp_control/dataa/datab   : latched values to FPALU
//    ofp_start                 : FPALU level-sensitive start
//    ifp_result, ifp_ready     : FPALU result and ready
//    owb_valid, owb_data,
//    owb_rd, owb_int           : writeback pulse and payload
//    oerror                    : timeout pulse
module fpalu_sequencer
    import fpalu_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        iclock,
    input  logic        ireset,
    input  logic        ivalid,
    input  logic [4:0]  icontrol,
    input  logic [31:0] idataa,
    input  logic [31:0] idatab,
    input  logic [4:0]  ird,
    input  logic        iwb_int,
    input  logic        iflush,
    output logic        oaccept,
    output logic        ostall,
    output logic [4:0]  ofp_control,
    output logic [31:0] ofp_dataa,
    output logic [31:0] ofp_datab,
    output logic        ofp_start,
    input  logic [31:0] ifp_result,
    input  logic        ifp_ready,
    output logic        owb_valid,
    output logic [31:0] owb_data,
    output logic [4:0]  owb_rd,
    output logic        owb_int,
    output logic        oerror
);

    seqState_e   state_q;
    logic        firstBusy_q;
    logic        fpStart_q;
    logic [4:0]  fpControl_q;
    logic [31:0] fpDataA_q;
    logic [31:0] fpDataB_q;
    logic [4:0]  pendRd_q;
    logic        pendInt_q;
    logic        wbValid_q;
    logic [31:0] wbData_q;
    logic [4:0]  wbRd_q;
    logic        wbInt_q;

    logic        accept;
    logic        busy;
    logic        timeoutHit;

    // The watchdog counter is a single counter; a zero limit has no meaning.
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("fpalu_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    assign accept = ivalid && !iflush && canAccept(state_q);
    assign busy   = (state_q == SEQ_BUSY);

`ifdef FPALU_SEQ_TIMEOUT_EN
    logic error_q;

    fpalu_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clock_i  (iclock),
        .reset_i  (ireset),
        .busy_i   (busy),
        .clear_i  (iflush),
        .expired_o(timeoutHit)
    );

    assign oerror = error_q;
`else
    assign timeoutHit = 1'b0;
    assign oerror     = 1'b0;
`endif

    // Whole sequencer FSM with its registered outputs. The rd/int target is
    // held in pend* during the operation and only copied to the writeback
    // payload on completion, so the payload never changes under owb_valid.
    // In BUSY, flush beats ready, and a real ready beats the watchdog.
    // firstBusy_q masks a ready left high by FPALU from the previous op.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            state_q     <= SEQ_IDLE;
            firstBusy_q <= 1'b0;
            fpStart_q   <= 1'b0;
            fpControl_q <= FOPNULL;
            fpDataA_q   <= '0;
            fpDataB_q   <= '0;
            pendRd_q    <= '0;
            pendInt_q   <= 1'b0;
            wbValid_q   <= 1'b0;
            wbData_q    <= '0;
            wbRd_q      <= '0;
            wbInt_q     <= 1'b0;
`ifdef FPALU_SEQ_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
        end else begin
            wbValid_q <= 1'b0;
`ifdef FPALU_SEQ_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
            case (state_q)
                SEQ_IDLE, SEQ_DONE: begin
                    state_q   <= SEQ_IDLE;
                    fpStart_q <= 1'b0;
                    if (accept) begin
                        state_q     <= SEQ_BUSY;
                        firstBusy_q <= 1'b1;
                        fpStart_q   <= 1'b1;
                        fpControl_q <= icontrol;
                        fpDataA_q   <= idataa;
                        fpDataB_q   <= idatab;
                        pendRd_q    <= ird;
                        pendInt_q   <= iwb_int;
                    end
                end
                SEQ_BUSY: begin
                    firstBusy_q <= 1'b0;
                    if (iflush) begin
                        state_q   <= SEQ_IDLE;
                        fpStart_q <= 1'b0;
                    end else if (ifp_ready && !firstBusy_q) begin
                        state_q   <= SEQ_DONE;
                        fpStart_q <= 1'b0;
                        wbValid_q <= 1'b1;
                        wbData_q  <= ifp_result;
                        wbRd_q    <= pendRd_q;
                        wbInt_q   <= pendInt_q;
                    end else if (timeoutHit) begin
                        state_q   <= SEQ_DONE;
                        fpStart_q <= 1'b0;
                        wbValid_q <= 1'b1;
                        wbData_q  <= FP_ERROR_PATTERN;
                        wbRd_q    <= pendRd_q;
                        wbInt_q   <= pendInt_q;
`ifdef FPALU_SEQ_TIMEOUT_EN
                        error_q   <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q   <= SEQ_IDLE;
                    fpStart_q <= 1'b0;
                end
            endcase
        end
    end

    assign oaccept     = accept;
    assign ostall      = busy;
    assign ofp_start   = fpStart_q;
    assign ofp_control = fpControl_q;
    assign ofp_dataa   = fpDataA_q;
    assign ofp_datab   = fpDataB_q;
    assign owb_valid   = wbValid_q;
    assign owb_data    = wbData_q;
    assign owb_rd      = wbRd_q;
    assign owb_int     = wbInt_q;

endmodule

// File: tb/tb_fpalu_sequencer.sv
// tb_fpalu_sequencer
//    Self-checking bench for fpalu_sequencer. A behavioural FPALU answers
//    N cycles of start after it first sees start high (ready registered, so it
//    may stay high for one cycle after start drops). Each request is checked
//    against the expected timeline: N+2 BUSY cycles, then one DONE cycle
//    carrying the FPALU result and the request's rd/int target.
module tb_fpalu_sequencer;
    import fpalu_sequencer_pkg::*;

    logic        iclock = 1'b0;
    logic        ireset = 1'b1;
    logic        ivalid = 1'b0;
    logic [4:0]  icontrol = '0;
    logic [31:0] idataa = '0;
    logic [31:0] idatab = '0;
    logic [4:0]  ird = '0;
    logic        iwb_int = 1'b0;
    logic        iflush = 1'b0;
    logic        oaccept;
    logic        ostall;
    logic [4:0]  ofp_control;
    logic [31:0] ofp_dataa;
    logic [31:0] ofp_datab;
    logic        ofp_start;
    logic [31:0] ifp_result;
    logic        ifp_ready;
    logic        owb_valid;
    logic [31:0] owb_data;
    logic [4:0]  owb_rd;
    logic        owb_int;
    logic        oerror;

    int vectorCount = 0;
    int mismatchCount = 0;

    int          fpN = 4;
    logic        fpStuck = 1'b0;
    logic [31:0] fpResultVal = '0;
    int          fpCnt = 0;
    logic        fpReadyQ = 1'b0;

    logic [4:0] opList [8] = '{FOPADD, FOPSUB, FOPMUL, FOPDIV, FOPSQRT, FOPABS, FOPCEQ, FOPCVTWS};

    always #5 iclock = ~iclock;

    fpalu_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .iclock     (iclock),
        .ireset     (ireset),
        .ivalid     (ivalid),
        .icontrol   (icontrol),
        .idataa     (idataa),
        .idatab     (idatab),
        .ird        (ird),
        .iwb_int    (iwb_int),
        .iflush     (iflush),
        .oaccept    (oaccept),
        .ostall     (ostall),
        .ofp_control(ofp_control),
        .ofp_dataa  (ofp_dataa),
        .ofp_datab  (ofp_datab),
        .ofp_start  (ofp_start),
        .ifp_result (ifp_result),
        .ifp_ready  (ifp_ready),
        .owb_valid  (owb_valid),
        .owb_data   (owb_data),
        .owb_rd     (owb_rd),
        .owb_int    (owb_int),
        .oerror     (oerror)
    );

    // Behavioural FPALU: counts cycles of start, restarts when start drops,
    // and raises a registered ready once fpN start cycles have been seen.
    always @(posedge iclock) begin
        if (ofp_start) fpCnt <= (fpCnt >= fpN) ? fpCnt : fpCnt + 1;
        else           fpCnt <= 0;
        fpReadyQ <= (fpCnt >= fpN) && !fpStuck;
    end

    assign ifp_ready  = fpReadyQ;
    assign ifp_result = fpResultVal;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_stall"}, ostall, 0);
        checkOutput({tag, "_start"}, ofp_start, 0);
        checkOutput({tag, "_wbvalid"}, owb_valid, 0);
        checkOutput({tag, "_error"}, oerror, 0);
        checkOutput({tag, "_wbdata"}, owb_data, 0);
        checkOutput({tag, "_wbrd"}, owb_rd, 0);
        checkOutput({tag, "_wbint"}, owb_int, 0);
        checkOutput({tag, "_control"}, ofp_control, FOPNULL);
        checkOutput({tag, "_dataa"}, ofp_dataa, 0);
        checkOutput({tag, "_datab"}, ofp_datab, 0);
        checkOutput({tag, "_accept"}, oaccept, 0);
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Issues one request and
    // follows it to completion (or to flush when flushAt names a BUSY cycle).
    // Returns at the DONE cycle when backToBack is set, else one cycle later.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic wbInt, input int n,
                                 input logic [31:0] result, input int flushAt, input bit backToBack);
        ivalid = 1'b1; icontrol = op; idataa = a; idatab = b; ird = rd; iwb_int = wbInt;
        fpN = n; fpResultVal = result;
        #1;
        checkOutput("accept", oaccept, 1);
        @(negedge iclock);
        ivalid = 1'b0; icontrol = 5'($urandom); idataa = $urandom; idatab = $urandom;
        ird = 5'($urandom); iwb_int = 1'($urandom);
        for (int j = 0; j <= n + 1; j++) begin
            checkOutput("busy_stall", ostall, 1);
            checkOutput("busy_start", ofp_start, 1);
            checkOutput("busy_wbvalid", owb_valid, 0);
            checkOutput("busy_control", ofp_control, op);
            checkOutput("busy_dataa", ofp_dataa, a);
            checkOutput("busy_datab", ofp_datab, b);
            if (j == flushAt) begin
                iflush = 1'b1;
                @(negedge iclock);
                iflush = 1'b0;
                checkOutput("flush_stall", ostall, 0);
                checkOutput("flush_start", ofp_start, 0);
                checkOutput("flush_wbvalid", owb_valid, 0);
                checkOutput("flush_error", oerror, 0);
                return;
            end
            @(negedge iclock);
        end
        checkOutput("done_wbvalid", owb_valid, 1);
        checkOutput("done_data", owb_data, result);
        checkOutput("done_rd", owb_rd, rd);
        checkOutput("done_int", owb_int, wbInt);
        checkOutput("done_stall", ostall, 0);
        checkOutput("done_start", ofp_start, 0);
        checkOutput("done_error", oerror, 0);
        if (!backToBack) begin
            @(negedge iclock);
            checkOutput("idle_wbvalid", owb_valid, 0);
            checkOutput("idle_stall", ostall, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        int fl;

        repeat (3) @(negedge iclock);
        ireset = 1'b0;
        checkResetValues("reset");

        // FOPADD 1.0 + 2.0 with a 6-cycle FPALU
        applyStimulus(FOPADD, 32'h3F800000, 32'h40000000, 5'd5, 1'b0, 6, 32'h40400000, -1, 1'b0);

        // FOPMUL then FOPABS accepted during the DONE cycle
        applyStimulus(FOPMUL, 32'h40400000, 32'hC0000000, 5'd7, 1'b0, 4, 32'hC0C00000, -1, 1'b1);
        applyStimulus(FOPABS, 32'hBF800000, 32'h0, 5'd9, 1'b0, 4, 32'h3F800000, -1, 1'b0);

        // Flush in the 3rd BUSY cycle, new request in the following cycle
        applyStimulus(FOPDIV, 32'h41200000, 32'h40000000, 5'd3, 1'b0, 6, 32'h40A00000, 2, 1'b0);
        applyStimulus(FOPSUB, 32'h40A00000, 32'h3F800000, 5'd4, 1'b0, 3, 32'h40800000, -1, 1'b0);

        // Flush in the cycle ready is seen: result discarded
        applyStimulus(FOPCEQ, 32'h3F800000, 32'h3F800000, 5'd11, 1'b1, 3, 32'h00000001, 4, 1'b0);
        checkOutput("post_flush_accept_idle", ostall, 0);

        // Reset in the middle of BUSY
        ivalid = 1'b1; icontrol = FOPDIV; idataa = 32'h12345678; idatab = 32'h9ABCDEF0;
        ird = 5'd20; iwb_int = 1'b1; fpN = 5;
        #1;
        checkOutput("rst_accept", oaccept, 1);
        @(negedge iclock);
        ivalid = 1'b0;
        repeat (2) @(negedge iclock);
        ireset = 1'b1;
        @(negedge iclock);
        ireset = 1'b0;
        checkResetValues("midreset");
        @(negedge iclock);

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(1, 6));
            fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n + 1)) : -1;
            applyStimulus(opList[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom), 1'($urandom),
                          n, $urandom, fl, 1'($urandom));
        end
        @(negedge iclock);

        // FPALU never answers
        fpStuck = 1'b1;
        ivalid = 1'b1; icontrol = FOPSQRT; idataa = 32'h40800000; idatab = '0;
        ird = 5'd17; iwb_int = 1'b0; fpN = 3;
        #1;
        checkOutput("stuck_accept", oaccept, 1);
        @(negedge iclock);
        ivalid = 1'b0;
`ifdef FPALU_SEQ_TIMEOUT_EN
        for (int j = 0; j < 8; j++) begin
            checkOutput("to_stall", ostall, 1);
            checkOutput("to_error_busy", oerror, 0);
            @(negedge iclock);
        end
        checkOutput("to_wbvalid", owb_valid, 1);
        checkOutput("to_data", owb_data, FP_ERROR_PATTERN);
        checkOutput("to_rd", owb_rd, 17);
        checkOutput("to_error", oerror, 1);
        checkOutput("to_stall_done", ostall, 0);
        @(negedge iclock);
        checkOutput("to_error_pulse", oerror, 0);
        checkOutput("to_wbvalid_pulse", owb_valid, 0);
`else
        repeat (100) @(negedge iclock);
        checkOutput("stuck_stall", ostall, 1);
        checkOutput("stuck_start", ofp_start, 1);
        checkOutput("stuck_wbvalid", owb_valid, 0);
        checkOutput("stuck_error", oerror, 0);
        iflush = 1'b1;
        @(negedge iclock);
        iflush = 1'b0;
        checkOutput("stuck_flush_stall", ostall, 0);
`endif
        repeat (2) @(negedge iclock);
        fpStuck = 1'b0;

        // Normal operation after recovery
        applyStimulus(FOPMV, 32'hCAFEF00D, 32'h0, 5'd31, 1'b1, 2, 32'hCAFEF00D, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, mismatchCount);
        $finish;
    end

endmodule
